// File: rtl/usb_tx_sequencer_if.sv
// Byte handshake and serial-side signals of the USB transmit sequencer.
// The slave modport is the sequencer; the master modport is its environment
// (packet builder on the byte side, bit stuffer on the serial side).
interface usb_tx_sequencer_if;
  logic [7:0] Tx_Seq_Data;
  logic       Tx_Seq_Valid;
  logic       Tx_Seq_Last;
  logic       Tx_Seq_Ready;
  logic       Tx_Seq_Bit_Out;
  logic       Tx_Seq_Stuff_Flag;
  logic       Tx_Seq_Active;
  logic       Tx_Seq_Eop;
  logic       Tx_Seq_Underrun;
  logic [7:0] Tx_Seq_Byte_Count;

  modport master (
    output Tx_Seq_Data, Tx_Seq_Valid, Tx_Seq_Last, Tx_Seq_Stuff_Flag,
    input  Tx_Seq_Ready, Tx_Seq_Bit_Out, Tx_Seq_Active, Tx_Seq_Eop,
           Tx_Seq_Underrun, Tx_Seq_Byte_Count
  );

  modport slave (
    input  Tx_Seq_Data, Tx_Seq_Valid, Tx_Seq_Last, Tx_Seq_Stuff_Flag,
    output Tx_Seq_Ready, Tx_Seq_Bit_Out, Tx_Seq_Active, Tx_Seq_Eop,
           Tx_Seq_Underrun, Tx_Seq_Byte_Count
  );
endinterface

// File: rtl/usb_tx_sequencer.sv
// USB transmit packet sequencer: accepts packet bytes, prepends SYNC,
// serialises LSB-first one bit per clock (stalling on stuff bits), then
// frames the packet with an EOP interval and an inter-packet gap.
module usb_tx_sequencer #(
  parameter logic [7:0]  SYNC_BYTE  = 8'h80,
  parameter int unsigned EOP_CYCLES = 2,
  parameter int unsigned GAP_CYCLES = 2
) (
  input logic              Tx_Seq_Clk,
  input logic              Tx_Seq_Rst,
  usb_tx_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP,
    S_GAP
  } state_t;

  localparam logic [15:0] EOP_LAST = 16'(EOP_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  sr_q, sr_d;
  logic [2:0]  idx_q, idx_d;
  logic        sr_last_q, sr_last_d;
  logic [7:0]  hr_q, hr_d;
  logic        hr_full_q, hr_full_d;
  logic        hr_last_q, hr_last_d;
  logic        last_acc_q, last_acc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic        bit_out_q, bit_out_d;
  logic        active_q, active_d;
  logic        eop_q, eop_d;
  logic        underrun_q, underrun_d;

  logic        ready;
  logic        accept;

  // Ready is held low during reset so no byte can slip in while the state is forced.
  always_comb begin
    ready = !Tx_Seq_Rst && !hr_full_q && !last_acc_q &&
            (state_q == S_IDLE || state_q == S_SYNC || state_q == S_DATA);
    accept = ready && bus.Tx_Seq_Valid;
  end

  // Next-state logic; outputs are derived from the next state so they register in step.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    idx_d      = idx_q;
    sr_last_d  = sr_last_q;
    hr_d       = hr_q;
    hr_full_d  = hr_full_q;
    hr_last_d  = hr_last_q;
    last_acc_d = last_acc_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    underrun_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          hr_d       = bus.Tx_Seq_Data;
          hr_full_d  = 1'b1;
          hr_last_d  = bus.Tx_Seq_Last;
          last_acc_d = bus.Tx_Seq_Last;
          byte_cnt_d = '0;
          sr_d       = SYNC_BYTE;
          sr_last_d  = 1'b0;
          idx_d      = '0;
          state_d    = S_SYNC;
        end
      end

      S_SYNC, S_DATA: begin
        // Refilling the holding register does not depend on stuffer stalls.
        if (accept) begin
          hr_d       = bus.Tx_Seq_Data;
          hr_full_d  = 1'b1;
          hr_last_d  = bus.Tx_Seq_Last;
          last_acc_d = last_acc_q | bus.Tx_Seq_Last;
        end
        if (!bus.Tx_Seq_Stuff_Flag) begin
          if (idx_q != 3'd7) begin
            idx_d = idx_q + 3'd1;
          end else begin
            // SYNC is not a data byte, so only DATA bytes are counted.
            if (state_q == S_DATA) byte_cnt_d = byte_cnt_q + 8'd1;
            if (hr_full_q) begin
              sr_d      = hr_q;
              sr_last_d = hr_last_q;
              hr_full_d = 1'b0;
              idx_d     = '0;
              state_d   = S_DATA;
            end else begin
              // End of packet, either normally (Last) or aborted for lack of data.
              // A byte caught in the holding register here is dropped.
              underrun_d = !sr_last_q;
              hr_full_d  = 1'b0;
              last_acc_d = 1'b0;
              cnt_d      = '0;
              state_d    = S_EOP;
            end
          end
        end
      end

      S_EOP: begin
        if (cnt_q == EOP_LAST) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    active_d  = (state_d == S_SYNC) || (state_d == S_DATA);
    bit_out_d = active_d ? sr_d[idx_d] : 1'b0;
    eop_d     = (state_d == S_EOP);
  end

  // State, control and output registers; the byte registers carry no reset.
  always_ff @(posedge Tx_Seq_Clk) begin
    sr_q <= sr_d;
    hr_q <= hr_d;
    if (Tx_Seq_Rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      sr_last_q  <= 1'b0;
      hr_full_q  <= 1'b0;
      hr_last_q  <= 1'b0;
      last_acc_q <= 1'b0;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      bit_out_q  <= 1'b0;
      active_q   <= 1'b0;
      eop_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sr_last_q  <= sr_last_d;
      hr_full_q  <= hr_full_d;
      hr_last_q  <= hr_last_d;
      last_acc_q <= last_acc_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      bit_out_q  <= bit_out_d;
      active_q   <= active_d;
      eop_q      <= eop_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.Tx_Seq_Ready      = ready;
  assign bus.Tx_Seq_Bit_Out    = bit_out_q;
  assign bus.Tx_Seq_Active     = active_q;
  assign bus.Tx_Seq_Eop        = eop_q;
  assign bus.Tx_Seq_Underrun   = underrun_q;
  assign bus.Tx_Seq_Byte_Count = byte_cnt_q;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Directed bench for usb_tx_sequencer: single byte, stuff stalls, underrun,
// back-to-back Valid through EOP/GAP, mid-packet reset, stall on SYNC bit 7.
module tb_usb_tx_sequencer;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [8:0] tx_q[$];

  int          act_cnt, eop_cnt, und_cnt, und_k, n;
  logic [23:0] stream;
  logic [15:0] exp1;
  logic [7:0]  pkt;

  usb_tx_sequencer_if bus_if();

  usb_tx_sequencer #(
    .SYNC_BYTE (8'h80),
    .EOP_CYCLES(2),
    .GAP_CYCLES(2)
  ) dut (
    .Tx_Seq_Clk(clk),
    .Tx_Seq_Rst(rst),
    .bus       (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Present the head of the byte queue (or nothing) on the handshake.
  task automatic refresh();
    if (tx_q.size() > 0) begin
      bus_if.Tx_Seq_Valid = 1'b1;
      bus_if.Tx_Seq_Last  = tx_q[0][8];
      bus_if.Tx_Seq_Data  = tx_q[0][7:0];
    end else begin
      bus_if.Tx_Seq_Valid = 1'b0;
      bus_if.Tx_Seq_Last  = 1'b0;
      bus_if.Tx_Seq_Data  = 8'h00;
    end
  endtask

  // Advance one clock, retiring the presented byte if it was accepted.
  task automatic next_cycle();
    logic hs;
    hs = bus_if.Tx_Seq_Ready && bus_if.Tx_Seq_Valid;
    @(negedge clk);
    if (hs) void'(tx_q.pop_front());
    refresh();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus_if.Tx_Seq_Data       = 8'h00;
    bus_if.Tx_Seq_Valid      = 1'b0;
    bus_if.Tx_Seq_Last       = 1'b0;
    bus_if.Tx_Seq_Stuff_Flag = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(bus_if.Tx_Seq_Ready), 0);
    chk("rst_bit", int'(bus_if.Tx_Seq_Bit_Out), 0);
    chk("rst_active", int'(bus_if.Tx_Seq_Active), 0);
    chk("rst_eop", int'(bus_if.Tx_Seq_Eop), 0);
    chk("rst_underrun", int'(bus_if.Tx_Seq_Underrun), 0);
    chk("rst_bytecount", int'(bus_if.Tx_Seq_Byte_Count), 0);
    rst = 1'b0;
    next_cycle();
    chk("ready_after_rst", int'(bus_if.Tx_Seq_Ready), 1);

    // Single byte 0xC3 with Last: SYNC 0x80 then 0xC3, LSB first
    exp1 = 16'hC380;
    tx_q.push_back({1'b1, 8'hC3});
    refresh();
    next_cycle();
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("t1_active%0d", k), int'(bus_if.Tx_Seq_Active), 1);
      chk($sformatf("t1_bit%0d", k), int'(bus_if.Tx_Seq_Bit_Out), int'(exp1[k-1]));
      chk($sformatf("t1_ready%0d", k), int'(bus_if.Tx_Seq_Ready), 0);
      if (k == 9) chk("t1_bc_start", int'(bus_if.Tx_Seq_Byte_Count), 0);
      next_cycle();
    end
    chk("t1_eop_a", int'(bus_if.Tx_Seq_Eop), 1);
    chk("t1_active_eop", int'(bus_if.Tx_Seq_Active), 0);
    chk("t1_bit_eop", int'(bus_if.Tx_Seq_Bit_Out), 0);
    chk("t1_bc", int'(bus_if.Tx_Seq_Byte_Count), 1);
    chk("t1_ready_eop", int'(bus_if.Tx_Seq_Ready), 0);
    chk("t1_underrun", int'(bus_if.Tx_Seq_Underrun), 0);
    next_cycle();
    chk("t1_eop_b", int'(bus_if.Tx_Seq_Eop), 1);
    next_cycle();
    chk("t1_eop_end", int'(bus_if.Tx_Seq_Eop), 0);
    chk("t1_ready_gap0", int'(bus_if.Tx_Seq_Ready), 0);
    next_cycle();
    chk("t1_ready_gap1", int'(bus_if.Tx_Seq_Ready), 0);
    next_cycle();
    chk("t1_ready_idle", int'(bus_if.Tx_Seq_Ready), 1);

    // 0xFF, 0xFF(Last) with stuff pulses after each sixth consecutive 1
    tx_q.push_back({1'b0, 8'hFF});
    tx_q.push_back({1'b1, 8'hFF});
    refresh();
    act_cnt = 0;
    eop_cnt = 0;
    n       = 0;
    stream  = '0;
    for (int k = 0; k <= 30; k++) begin
      bus_if.Tx_Seq_Stuff_Flag = (k == 14) || (k == 21);
      if (k >= 1) begin
        if (bus_if.Tx_Seq_Active) act_cnt++;
        if (bus_if.Tx_Seq_Active && !bus_if.Tx_Seq_Stuff_Flag) begin
          if (n < 24) stream[n] = bus_if.Tx_Seq_Bit_Out;
          n++;
        end
        if (bus_if.Tx_Seq_Eop) eop_cnt++;
      end
      next_cycle();
    end
    bus_if.Tx_Seq_Stuff_Flag = 1'b0;
    chk("t2_active_len", act_cnt, 26);
    chk("t2_consumed", n, 24);
    chk("t2_stream", int'(stream), int'(24'hFFFF80));
    chk("t2_eop_len", eop_cnt, 2);
    chk("t2_ready_idle", int'(bus_if.Tx_Seq_Ready), 1);

    // Underrun: 0xA5, 0x3C then third byte withheld
    tx_q.push_back({1'b0, 8'hA5});
    tx_q.push_back({1'b0, 8'h3C});
    refresh();
    und_cnt = 0;
    und_k   = -1;
    for (int k = 0; k <= 29; k++) begin
      if (k == 26) begin
        tx_q.push_back({1'b1, 8'h5A});
        refresh();
      end
      if (bus_if.Tx_Seq_Underrun) begin
        und_cnt++;
        und_k = k;
      end
      if (k == 24) chk("t3_active_last", int'(bus_if.Tx_Seq_Active), 1);
      if (k == 25) begin
        chk("t3_eop", int'(bus_if.Tx_Seq_Eop), 1);
        chk("t3_bc", int'(bus_if.Tx_Seq_Byte_Count), 2);
        chk("t3_active_off", int'(bus_if.Tx_Seq_Active), 0);
      end
      if (k >= 26 && k <= 28) chk($sformatf("t3_ready_late%0d", k), int'(bus_if.Tx_Seq_Ready), 0);
      if (k == 29) chk("t3_ready_idle", int'(bus_if.Tx_Seq_Ready), 1);
      next_cycle();
    end
    chk("t3_underrun_count", und_cnt, 1);
    chk("t3_underrun_time", und_k, 25);

    // Packet 0x5A in flight; next packet's Valid held high throughout
    pkt = 8'h5A;
    tx_q.push_back({1'b0, 8'h11});
    tx_q.push_back({1'b0, 8'h22});
    tx_q.push_back({1'b1, 8'h33});
    refresh();
    for (int k = 1; k <= 21; k++) begin
      if (k <= 20) chk($sformatf("t4_ready%0d", k), int'(bus_if.Tx_Seq_Ready), 0);
      if (k >= 9 && k <= 16) chk($sformatf("t4_bit%0d", k), int'(bus_if.Tx_Seq_Bit_Out), int'(pkt[k-9]));
      if (k == 17) begin
        chk("t4_eop", int'(bus_if.Tx_Seq_Eop), 1);
        chk("t4_bc", int'(bus_if.Tx_Seq_Byte_Count), 1);
      end
      if (k == 21) chk("t4_ready_idle", int'(bus_if.Tx_Seq_Ready), 1);
      next_cycle();
    end

    // Reset at index 4 of the third byte (0x33)
    for (int k = 1; k <= 28; k++) next_cycle();
    chk("t5_active_pre", int'(bus_if.Tx_Seq_Active), 1);
    chk("t5_bc_pre", int'(bus_if.Tx_Seq_Byte_Count), 2);
    chk("t5_bit_pre", int'(bus_if.Tx_Seq_Bit_Out), 1);
    rst = 1'b1;
    next_cycle();
    chk("t5_active_rst", int'(bus_if.Tx_Seq_Active), 0);
    chk("t5_eop_rst", int'(bus_if.Tx_Seq_Eop), 0);
    chk("t5_bc_rst", int'(bus_if.Tx_Seq_Byte_Count), 0);
    chk("t5_bit_rst", int'(bus_if.Tx_Seq_Bit_Out), 0);
    chk("t5_ready_rst", int'(bus_if.Tx_Seq_Ready), 0);
    rst = 1'b0;
    next_cycle();
    chk("t5_ready_after", int'(bus_if.Tx_Seq_Ready), 1);
    chk("t5_no_eop_a", int'(bus_if.Tx_Seq_Eop), 0);
    next_cycle();
    chk("t5_no_eop_b", int'(bus_if.Tx_Seq_Eop), 0);
    chk("t5_idle_active", int'(bus_if.Tx_Seq_Active), 0);

    // Stuff on SYNC index 7 and held through EOP and GAP
    tx_q.push_back({1'b1, 8'hC3});
    refresh();
    act_cnt = 0;
    eop_cnt = 0;
    for (int k = 0; k <= 22; k++) begin
      bus_if.Tx_Seq_Stuff_Flag = (k == 8) || (k >= 18 && k <= 21);
      if (bus_if.Tx_Seq_Active) act_cnt++;
      if (bus_if.Tx_Seq_Eop) eop_cnt++;
      if (k == 9) begin
        chk("t6_sync7_held", int'(bus_if.Tx_Seq_Bit_Out), 1);
        chk("t6_active_held", int'(bus_if.Tx_Seq_Active), 1);
      end
      if (k == 11) chk("t6_data_bit1", int'(bus_if.Tx_Seq_Bit_Out), 1);
      if (k == 12) chk("t6_data_bit2", int'(bus_if.Tx_Seq_Bit_Out), 0);
      if (k == 18 || k == 19) chk($sformatf("t6_eop%0d", k), int'(bus_if.Tx_Seq_Eop), 1);
      if (k == 20) chk("t6_eop_end", int'(bus_if.Tx_Seq_Eop), 0);
      if (k == 22) chk("t6_ready_idle", int'(bus_if.Tx_Seq_Ready), 1);
      next_cycle();
    end
    bus_if.Tx_Seq_Stuff_Flag = 1'b0;
    chk("t6_active_len", act_cnt, 17);
    chk("t6_eop_len", eop_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/usb_tx_sequencer.md
# usb_tx_sequencer

Transmit-side packet sequencer for the USB transceiver. It takes packet bytes over a valid/ready handshake, prepends the SYNC byte, and serialises everything LSB-first into the bit-stuff stage one bit per clock. It stalls whenever the bit stuffer inserts a stuff bit, then frames the packet with an EOP interval and an inter-packet gap. It sits between the packet/PID builder and the bit stuffer; the stuffer output continues to the NRZI encoder.

## Interface
Parameters:
- SYNC_BYTE, 8'h80, SYNC pattern, sent LSB-first.
- EOP_CYCLES, 2, EOP length in clocks, ≥1.
- GAP_CYCLES, 2, idle clocks after EOP before the next packet is accepted, ≥1.

Ports:
- Tx_Seq_Clk  in  1  single clock; all logic on rising edge.
- Tx_Seq_Rst  in  1  synchronous, active-high reset.
- Tx_Seq_Data  in  8  packet byte.
- Tx_Seq_Valid  in  1  Tx_Seq_Data valid.
- Tx_Seq_Last  in  1  qualifies the byte as the final byte of the packet.
- Tx_Seq_Ready  out  1  byte accepted on any clock with Valid&Ready.
- Tx_Seq_Bit_Out  out  1  serial bit to the bit stuffer data input.
- Tx_Seq_Stuff_Flag  in  1  from the bit stuffer; high means the stuffer is inserting a stuff bit and ignores its input this cycle.
- Tx_Seq_Active  out  1  high while SYNC or data bits are driven.
- Tx_Seq_Eop  out  1  high during the EOP interval.
- Tx_Seq_Underrun  out  1  one-clock pulse when a packet is aborted for lack of data.
- Tx_Seq_Byte_Count  out  8  data bytes fully shifted in the current or last packet, excluding SYNC; wraps at 256.

## Operation
- State machine: IDLE → SYNC → DATA → EOP → GAP → IDLE.
- Registers:
  - 8-bit shift register (SR) with a 3-bit bit index.
  - One-byte holding register (HR) with full flag and last flag.
  - Last-accepted flag.
  - EOP/GAP cycle counter.
- Ready = HR empty AND state ∈ {IDLE, SYNC, DATA} AND no Last byte accepted yet in this packet.
- IDLE:
  - Bit_Out=0, Active=0.
  - On accept: byte goes to HR, Byte_Count←0, SR←SYNC_BYTE, index←0, next state SYNC.
- SYNC/DATA:
  - Bit_Out = SR[index], Active=1.
  - Each clock with Stuff_Flag=0: the bit is consumed and index increments.
  - Each clock with Stuff_Flag=1: nothing advances and Bit_Out is re-presented unchanged next clock.
  - On consuming index 7:
    - If HR is full: SR←HR, HR emptied, index←0, state DATA. In DATA, Byte_Count increments.
    - Else if the consumed byte carried Last: Byte_Count increments (in DATA), state EOP.
    - Else, in DATA (non-last byte with HR empty): Underrun pulses, Byte_Count increments, state EOP (abort).
    - In SYNC, HR is always full, since the first byte was accepted in IDLE.
- Bytes accepted into HR during SYNC/DATA are independent of Stuff_Flag.
- EOP:
  - Bit_Out=0, Active=0, Eop=1 for exactly EOP_CYCLES clocks.
  - On abort, a still-full HR is discarded.
- GAP: all outputs 0, Ready=0 for GAP_CYCLES clocks, then IDLE.
- Stuff_Flag is ignored in IDLE, EOP and GAP.

## Timing
- Reset values: Ready=0, Bit_Out=0, Active=0, Eop=0, Underrun=0, Byte_Count=0; state IDLE, HR empty. Ready=1 on the first clock after Rst deasserts.
- Reset mid-packet: abandon immediately with no EOP; outputs take reset values on the next edge.
- All outputs are registered except Ready, which is a combinational function of registered state.
- Accept at edge t:
  - SYNC bit 0 drives during cycle t+1.
  - Data bit 0 of byte 0 drives at t+9, plus one cycle per Stuff_Flag-high cycle.
- Stall-free packet of N bytes: Active high for 8+8N clocks, then Eop high EOP_CYCLES clocks, then GAP_CYCLES clocks.
- Minimum accept-to-accept spacing for back-to-back packets: 1+8+8N+EOP_CYCLES+GAP_CYCLES clocks.
- Underrun is asserted on the clock in which EOP begins, together with Eop.
- Stuff_Flag high on the same clock as index 7 holds index 7; the byte switch is deferred one clock.

## Test plan
- Single byte 0xC3 with Last, no stalls → Bit_Out sequence 0,0,0,0,0,0,0,1, 1,1,0,0,0,0,1,1; then Eop high 2 clocks; Byte_Count=1; Ready low from accept until GAP ends.
- Bytes 0xFF, 0xFF (Last); Stuff_Flag pulsed for one clock after each sixth consecutive 1 consumed → each pulse extends Active by exactly 1 clock (total 24 + pulses); no bit is lost or duplicated in the consumed stream.
- 3-byte packet with byte 2 Valid withheld until 10 clocks after byte 1 enters SR → Underrun pulses once with Eop at byte 1's index-7 consumption; Byte_Count=2; late byte not accepted until after GAP.
- Second packet's Valid held high throughout the first packet's EOP and GAP → Ready stays 0 through EOP_CYCLES+GAP_CYCLES clocks, then the byte is accepted on the first IDLE clock.
- Rst asserted mid-DATA (index 4, byte 2) → next clock: Active=0, Eop=0, Byte_Count=0, no EOP emitted; Ready=1 one clock after deassert.
- Stuff_Flag held high on the SYNC index-7 clock and throughout EOP → SYNC-to-data transition delayed by 1 clock; EOP length is still exactly 2.
